// File: rtl/spi_target.sv
// spi_target: memory-mapped SPI target (CPHA=0, MSB first) with a byte FIFO
// in each direction. SCK, SS_N and MOSI are asynchronous and are oversampled
// in the clk domain. The CPU sees four word registers: data, status, ctrl, fill.
module spi_target #(
    parameter logic       POLARITY = 1'b0,
    parameter int         DEPTH    = 4,
    parameter logic [7:0] FILL     = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        select,
    input  logic [3:0]  we,
    input  logic        rd,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        interrupt,
    input  logic        spi_sck,
    input  logic        spi_ss_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe
);

    localparam int              AW      = $clog2(DEPTH);
    localparam int              PW      = AW + 1;
    localparam logic [PW-1:0]   DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0]   PTR_ONE = PW'(1);
    localparam logic [3:0]      LAST_BIT = 4'd7;
    localparam logic [3:0]      BYTE_DONE = 4'd8;
    // Synchroniser bit order is {mosi, ss_n, sck}; idle line levels.
    localparam logic [2:0]      SYNC_IDLE = {1'b0, 1'b1, POLARITY};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]    sync1_q, sync1_d;
    logic [2:0]    sync2_q, sync2_d;
    logic          sck_prev_q, sck_prev_d;
    logic          ss_prev_q, ss_prev_d;

    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          miso_q, miso_d;
    logic          miso_oe_q, miso_oe_d;

    logic [PW-1:0] tx_wr_ptr_q, tx_wr_ptr_d;
    logic [PW-1:0] tx_rd_ptr_q, tx_rd_ptr_d;
    logic [PW-1:0] rx_wr_ptr_q, rx_wr_ptr_d;
    logic [PW-1:0] rx_rd_ptr_q, rx_rd_ptr_d;

    // flags: [0] rx_overflow [1] tx_underrun [2] tx_overflow
    logic [2:0]    flags_q, flags_d;
    logic [2:0]    ctrl_q, ctrl_d;
    logic [7:0]    fill_q, fill_d;

    // ------------------------------------------------------------------
    // Derived signals
    // ------------------------------------------------------------------
    logic          sck_s, ss_n_s, mosi_s;
    logic          sck_lvl, sck_prev_lvl;
    logic          lead_edge, trail_edge;
    logic          ss_fall, ss_rise, ss_active;

    logic [PW-1:0] tx_count, rx_count;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic [7:0]    tx_head, rx_head;
    logic [7:0]    tx_mem [DEPTH];
    logic [7:0]    rx_mem [DEPTH];

    logic          bus_wr, bus_rd;
    logic          tx_cpu_req, tx_push, tx_spi_pop;
    logic          rx_spi_req, rx_push, rx_cpu_pop;
    logic          tx_load;
    logic [7:0]    load_byte;
    logic [7:0]    rx_byte;
    logic [2:0]    flag_set, flag_clr;

    logic          unused_bits;
    assign unused_bits = ^{we[3:1], wdata[31:8]};

    assign sck_s  = sync2_q[0];
    assign ss_n_s = sync2_q[1];
    assign mosi_s = sync2_q[2];

    // Normalise SCK so that 0 is always the idle level; the leading edge is
    // then a 0->1 transition regardless of polarity.
    assign sck_lvl      = sck_s ^ POLARITY;
    assign sck_prev_lvl = sck_prev_q ^ POLARITY;
    assign lead_edge    = sck_lvl & ~sck_prev_lvl;
    assign trail_edge   = ~sck_lvl & sck_prev_lvl;

    assign ss_fall   = ss_prev_q & ~ss_n_s;
    assign ss_rise   = ~ss_prev_q & ss_n_s;
    assign ss_active = ~ss_n_s;

    assign tx_count = tx_wr_ptr_q - tx_rd_ptr_q;
    assign rx_count = rx_wr_ptr_q - rx_rd_ptr_q;
    assign tx_full  = (tx_count == DEPTH_P);
    assign tx_empty = (tx_count == '0);
    assign rx_full  = (rx_count == DEPTH_P);
    assign rx_empty = (rx_count == '0);
    assign tx_head  = tx_mem[tx_rd_ptr_q[AW-1:0]];
    assign rx_head  = rx_mem[rx_rd_ptr_q[AW-1:0]];

    assign bus_wr = select & we[0];
    assign bus_rd = select & rd;

    // ------------------------------------------------------------------
    // FIFO storage: one byte register per entry, no reset needed since an
    // entry is only ever read after it has been written.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_fifo_mem
            logic [7:0] tx_ent_q, tx_ent_d;
            logic [7:0] rx_ent_q, rx_ent_d;

            // Capture a pushed byte when this entry is the write target.
            always_comb begin
                tx_ent_d = tx_ent_q;
                rx_ent_d = rx_ent_q;
                if (tx_push && (tx_wr_ptr_q[AW-1:0] == AW'(gi)))
                    tx_ent_d = wdata[7:0];
                if (rx_push && (rx_wr_ptr_q[AW-1:0] == AW'(gi)))
                    rx_ent_d = rx_byte;
            end

            // Entry storage registers.
            always_ff @(posedge clk) begin
                tx_ent_q <= tx_ent_d;
                rx_ent_q <= rx_ent_d;
            end

            assign tx_mem[gi] = tx_ent_q;
            assign rx_mem[gi] = rx_ent_q;
        end
    endgenerate

    // Two-stage synchronisers and previous-sample registers for edge detection.
    always_comb begin
        sync1_d    = {spi_mosi, spi_ss_n, spi_sck};
        sync2_d    = sync1_q;
        sck_prev_d = sync2_q[0];
        ss_prev_d  = sync2_q[1];
    end

    // SPI engine: frame start/stop, bit shifting and byte boundaries.
    always_comb begin
        bitcnt_d   = bitcnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        miso_d     = miso_q;
        miso_oe_d  = miso_oe_q;
        tx_load    = 1'b0;
        rx_spi_req = 1'b0;
        rx_byte    = {rx_shift_q[6:0], mosi_s};
        load_byte  = tx_empty ? fill_q : tx_head;

        if (ss_rise) begin
            // Frame ended: any partial byte and the loaded TX byte are dropped.
            bitcnt_d  = '0;
            miso_oe_d = 1'b0;
            miso_d    = 1'b1;
        end else if (ss_fall) begin
            tx_load   = 1'b1;
            bitcnt_d  = '0;
            miso_oe_d = 1'b1;
        end else if (ss_active) begin
            if (lead_edge) begin
                rx_shift_d = rx_byte;
                bitcnt_d   = bitcnt_q + 4'd1;
                if (bitcnt_q == LAST_BIT)
                    rx_spi_req = 1'b1;
            end else if (trail_edge) begin
                if (bitcnt_q == BYTE_DONE) begin
                    // Byte boundary: the next byte goes out back to back.
                    tx_load  = 1'b1;
                    bitcnt_d = '0;
                end else begin
                    tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    miso_d     = tx_shift_q[6];
                end
            end
        end

        if (tx_load) begin
            tx_shift_d = load_byte;
            miso_d     = load_byte[7];
        end
    end

    // FIFO pointer control. Full/empty decisions always use the pre-cycle
    // state, so a push to a full FIFO is dropped even if a pop happens too.
    always_comb begin
        tx_cpu_req = bus_wr && (addr == 2'd0);
        tx_push    = tx_cpu_req && !tx_full;
        tx_spi_pop = tx_load && !tx_empty;
        rx_push    = rx_spi_req && !rx_full;
        rx_cpu_pop = bus_rd && (addr == 2'd0) && !rx_empty;

        tx_wr_ptr_d = tx_push    ? tx_wr_ptr_q + PTR_ONE : tx_wr_ptr_q;
        tx_rd_ptr_d = tx_spi_pop ? tx_rd_ptr_q + PTR_ONE : tx_rd_ptr_q;
        rx_wr_ptr_d = rx_push    ? rx_wr_ptr_q + PTR_ONE : rx_wr_ptr_q;
        rx_rd_ptr_d = rx_cpu_pop ? rx_rd_ptr_q + PTR_ONE : rx_rd_ptr_q;
    end

    // Sticky error flags (write-1-to-clear, set wins) and CPU registers.
    always_comb begin
        flag_set = {tx_cpu_req && tx_full,
                    tx_load && tx_empty,
                    rx_spi_req && rx_full};
        flag_clr = (bus_wr && (addr == 2'd1)) ? wdata[5:3] : 3'b000;
        flags_d  = (flags_q & ~flag_clr) | flag_set;
        ctrl_d   = (bus_wr && (addr == 2'd2)) ? wdata[2:0] : ctrl_q;
        fill_d   = (bus_wr && (addr == 2'd3)) ? wdata[7:0] : fill_q;
    end

    // All control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= SYNC_IDLE;
            sync2_q     <= SYNC_IDLE;
            sck_prev_q  <= POLARITY;
            ss_prev_q   <= 1'b1;
            bitcnt_q    <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            miso_q      <= 1'b1;
            miso_oe_q   <= 1'b0;
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            flags_q     <= '0;
            ctrl_q      <= '0;
            fill_q      <= FILL;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            sck_prev_q  <= sck_prev_d;
            ss_prev_q   <= ss_prev_d;
            bitcnt_q    <= bitcnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
            flags_q     <= flags_d;
            ctrl_q      <= ctrl_d;
            fill_q      <= fill_d;
        end
    end

    // Register read mux; the data register reads as zero when RX is empty.
    always_comb begin
        rdata = '0;
        case (addr)
            2'd0: begin
                if (!rx_empty)
                    rdata = {23'b0, 1'b1, rx_head};
            end
            2'd1: rdata = {16'b0, 8'(rx_count), 1'b0, ss_active,
                           flags_q[2], flags_q[1], flags_q[0],
                           tx_empty, tx_full, !rx_empty};
            2'd2: rdata = {29'b0, ctrl_q};
            default: rdata = {24'b0, fill_q};
        endcase
    end

    // Level interrupt from enabled sources.
    always_comb begin
        interrupt = (!rx_empty && ctrl_q[0])
                  | (tx_empty && ctrl_q[1])
                  | ((|flags_q) && ctrl_q[2]);
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = miso_oe_q;

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: register table, directed SPI sequences
// and randomized traffic checked against a queue-based reference model.
module tb_spi_target;

    localparam int DEPTH = 4;
    localparam int HALF  = 4;   // SCK half period in clk cycles (SCK = clk/8)

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        select0 = 1'b0, select1 = 1'b0;
    logic [3:0]  we = 4'h0;
    logic        rd = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata0, rdata1;
    logic        irq0, irq1;
    logic        sck0 = 1'b0, ss0 = 1'b1, mosi0 = 1'b0;
    logic        sck1 = 1'b1, ss1 = 1'b1, mosi1 = 1'b0;
    logic        miso0, oe0, miso1, oe1;

    always #5 clk = ~clk;

    spi_target #(.POLARITY(1'b0), .DEPTH(DEPTH), .FILL(8'hFF)) dut (
        .clk(clk), .reset(reset), .select(select0), .we(we), .rd(rd),
        .addr(addr), .wdata(wdata), .rdata(rdata0), .interrupt(irq0),
        .spi_sck(sck0), .spi_ss_n(ss0), .spi_mosi(mosi0),
        .spi_miso(miso0), .spi_miso_oe(oe0));

    spi_target #(.POLARITY(1'b1), .DEPTH(DEPTH), .FILL(8'hFF)) dut1 (
        .clk(clk), .reset(reset), .select(select1), .we(we), .rd(rd),
        .addr(addr), .wdata(wdata), .rdata(rdata1), .interrupt(irq1),
        .spi_sck(sck1), .spi_ss_n(ss1), .spi_mosi(mosi1),
        .spi_miso(miso1), .spi_miso_oe(oe1));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of the POLARITY=0 instance
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic       m_rxovf = 1'b0, m_txund = 1'b0, m_txovf = 1'b0;
    logic [2:0] m_ctrl = 3'd0;
    logic [7:0] m_fill = 8'hFF;

    logic [7:0]  mo_g [8];
    logic [7:0]  mi_g [8];
    logic        oe_first_g;
    int          pop_bit_g = -1;
    logic [31:0] pop_data_g;

    typedef struct {
        logic        do_wr;
        logic [1:0]  a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        int rc;
        rc = rx_q.size();
        return {16'h0, 8'(rc), 1'b0, 1'b0, m_txovf, m_txund, m_rxovf,
                (tx_q.size() == 0), (tx_q.size() == DEPTH), (rc != 0)};
    endfunction

    function automatic logic exp_irq();
        return ((rx_q.size() != 0) && m_ctrl[0]) || ((tx_q.size() == 0) && m_ctrl[1])
            || ((m_rxovf || m_txund || m_txovf) && m_ctrl[2]);
    endfunction

    task automatic bus_write(input int which, input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; wdata = d; we = 4'h1;
        if (which == 0) select0 = 1'b1; else select1 = 1'b1;
        @(negedge clk);
        we = 4'h0; select0 = 1'b0; select1 = 1'b0;
        $display("bus%0d write addr=%0d data=0x%08h", which, a, d);
    endtask

    task automatic bus_read(input int which, input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a; rd = 1'b1;
        if (which == 0) select0 = 1'b1; else select1 = 1'b1;
        #1 d = (which == 0) ? rdata0 : rdata1;
        @(negedge clk);
        rd = 1'b0; select0 = 1'b0; select1 = 1'b0;
        $display("bus%0d read  addr=%0d data=0x%08h", which, a, d);
    endtask

    // CPU write to the modelled instance, mirrored into the model.
    task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
        bus_write(0, a, d);
        case (a)
            2'd0: if (tx_q.size() == DEPTH) m_txovf = 1'b1; else tx_q.push_back(d[7:0]);
            2'd1: begin
                if (d[3]) m_rxovf = 1'b0;
                if (d[4]) m_txund = 1'b0;
                if (d[5]) m_txovf = 1'b0;
            end
            2'd2: m_ctrl = d[2:0];
            default: m_fill = d[7:0];
        endcase
    endtask

    task automatic cpu_read_rx(input string name, output logic [31:0] got);
        logic [31:0] exp;
        bus_read(0, 2'd0, got);
        if (rx_q.size() != 0) exp = {23'b0, 1'b1, rx_q.pop_front()};
        else exp = 32'h0;
        chk(name, got, exp);
    endtask

    task automatic check_status(input string name);
        logic [31:0] st;
        bus_read(0, 2'd1, st);
        chk({name, " status"}, st, exp_status());
        chk({name, " irq"}, {31'b0, irq0}, {31'b0, exp_irq()});
    endtask

    task automatic set_spi(input int which, input logic s, input logic n, input logic m);
        if (which == 0) begin sck0 = s; ss0 = n; mosi0 = m; end
        else begin sck1 = s; ss1 = n; mosi1 = m; end
    endtask

    // Drive one SPI frame of nbits bits from mo_g, capturing MISO into mi_g.
    task automatic spi_frame(input int which, input int nbits);
        logic idle;
        logic cur_m;
        idle = (which != 0);
        cur_m = 1'b0;
        for (int i = 0; i < 8; i++) mi_g[i] = 8'h00;
        oe_first_g = 1'b0;
        @(negedge clk);
        set_spi(which, idle, 1'b0, cur_m);
        repeat (6) @(negedge clk);
        for (int b = 0; b < nbits; b++) begin
            cur_m = mo_g[b / 8][7 - (b % 8)];
            set_spi(which, idle, 1'b0, cur_m);
            repeat (HALF) @(negedge clk);
            set_spi(which, ~idle, 1'b0, cur_m);
            mi_g[b / 8][7 - (b % 8)] = (which == 0) ? miso0 : miso1;
            if (b == 0) oe_first_g = (which == 0) ? oe0 : oe1;
            for (int c = 0; c < HALF; c++) begin
                @(negedge clk);
                if (which == 0 && b == pop_bit_g) begin
                    if (c == 1) begin
                        addr = 2'd0; rd = 1'b1; select0 = 1'b1;
                        #1 pop_data_g = rdata0;
                    end else if (c == 2) begin
                        rd = 1'b0; select0 = 1'b0;
                    end
                end
            end
            set_spi(which, idle, 1'b0, cur_m);
        end
        repeat (HALF) @(negedge clk);
        set_spi(which, idle, 1'b1, cur_m);
        repeat (8) @(negedge clk);
        $display("spi%0d frame bits=%0d mosi0=0x%02h miso0=0x%02h", which, nbits, mo_g[0], mi_g[0]);
    endtask

    // Frame on the modelled instance: each loaded byte is the TX head or
    // the fill byte; each completed byte lands in RX unless RX is full.
    task automatic spi_run(input string name, input int nbits);
        int nfull, rem;
        logic [7:0] ld, mask;
        logic [31:0] pexp;
        spi_frame(0, nbits);
        nfull = nbits / 8;
        rem = nbits % 8;
        chk({name, " oe active"}, {31'b0, oe_first_g}, 32'd1);
        for (int k = 0; k <= nfull; k++) begin
            if (tx_q.size() != 0) ld = tx_q.pop_front();
            else begin ld = m_fill; m_txund = 1'b1; end
            if (k < nfull) begin
                chk($sformatf("%s miso byte%0d", name, k), {24'b0, mi_g[k]}, {24'b0, ld});
                if (pop_bit_g >= 0 && pop_bit_g / 8 == k) begin
                    pexp = (rx_q.size() != 0) ? {23'b0, 1'b1, rx_q.pop_front()} : 32'h0;
                    chk({name, " same-cycle pop"}, pop_data_g, pexp);
                end
                if (rx_q.size() == DEPTH) m_rxovf = 1'b1;
                else rx_q.push_back(mo_g[k]);
            end else if (rem > 0) begin
                mask = 8'hFF;
                mask = mask << (8 - rem);
                chk({name, " miso partial"}, {24'b0, mi_g[k]}, {24'b0, ld & mask});
            end
        end
        chk({name, " oe idle"}, {30'b0, oe0, miso0}, 32'd1);
        pop_bit_g = -1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [10];
        logic [31:0] d;

        vecs[0] = '{1'b0, 2'd1, 32'h0,        32'h0000_0004, 1'b0};
        vecs[1] = '{1'b0, 2'd0, 32'h0,        32'h0000_0000, 1'b0};
        vecs[2] = '{1'b0, 2'd2, 32'h0,        32'h0000_0000, 1'b0};
        vecs[3] = '{1'b0, 2'd3, 32'h0,        32'h0000_00FF, 1'b0};
        vecs[4] = '{1'b1, 2'd2, 32'hFFFF_FFFF, 32'h0000_0007, 1'b1};
        vecs[5] = '{1'b1, 2'd2, 32'h0000_0002, 32'h0000_0002, 1'b1};
        vecs[6] = '{1'b1, 2'd2, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[7] = '{1'b1, 2'd3, 32'h1234_5A6B, 32'h0000_006B, 1'b0};
        vecs[8] = '{1'b1, 2'd3, 32'h0000_00FF, 32'h0000_00FF, 1'b0};
        vecs[9] = '{1'b1, 2'd1, 32'hFFFF_FFFF, 32'h0000_0004, 1'b0};

        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset pins", {29'b0, irq0, oe0, miso0}, 32'd1);

        // Register table
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].do_wr) cpu_write(vecs[i].a, vecs[i].wd);
            bus_read(0, vecs[i].a, d);
            chk($sformatf("vec%0d rdata", i), d, vecs[i].exp_rd);
            chk($sformatf("vec%0d irq", i), {31'b0, irq0}, {31'b0, vecs[i].exp_irq});
        end

        // 1: single byte each way
        cpu_write(2'd0, 32'hA5);
        mo_g[0] = 8'h3C;
        spi_run("t1", 8);
        chk("t1 miso A5", {24'b0, mi_g[0]}, 32'hA5);
        bus_read(0, 2'd1, d);
        chk("t1 rx_nonempty", {31'b0, d[0]}, 32'd1);
        cpu_read_rx("t1 rx", d);
        chk("t1 rx 13C", d, 32'h13C);
        bus_read(0, 2'd1, d);
        chk("t1 rx_empty", {31'b0, d[0]}, 32'd0);

        // 2: underrun sends fill, error interrupt, write-1-to-clear
        cpu_write(2'd1, 32'h38);
        cpu_write(2'd2, 32'h4);
        mo_g[0] = 8'h5A; mo_g[1] = 8'hC3;
        spi_run("t2", 16);
        chk("t2 miso", {16'b0, mi_g[0], mi_g[1]}, 32'hFFFF);
        bus_read(0, 2'd1, d);
        chk("t2 underrun", {31'b0, d[4]}, 32'd1);
        chk("t2 irq set", {31'b0, irq0}, 32'd1);
        cpu_write(2'd1, 32'h10);
        chk("t2 irq clr", {31'b0, irq0}, 32'd0);
        check_status("t2");
        cpu_read_rx("t2 rx0", d);
        cpu_read_rx("t2 rx1", d);

        // 3: RX overflow keeps the first DEPTH bytes
        for (int i = 0; i < 5; i++) mo_g[i] = 8'(8'h11 * (i + 1));
        spi_run("t3", 40);
        bus_read(0, 2'd1, d);
        chk("t3 rx_overflow", {31'b0, d[3]}, 32'd1);
        chk("t3 rx_count", {24'b0, d[15:8]}, DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            cpu_read_rx($sformatf("t3 rx%0d", i), d);
            chk($sformatf("t3 order%0d", i), d, 32'h100 | 32'(8'h11 * (i + 1)));
        end
        cpu_write(2'd1, 32'h38);

        // 4: aborted partial byte, then a clean frame
        mo_g[0] = 8'hFF;
        spi_run("t4a", 5);
        chk("t4 oe dropped", {31'b0, oe0}, 32'd0);
        check_status("t4a");
        mo_g[0] = 8'h81;
        spi_run("t4b", 8);
        cpu_read_rx("t4 rx", d);
        chk("t4 rx 181", d, 32'h181);
        cpu_write(2'd1, 32'h38);

        // 5: CPU pop coinciding with SPI push at count=2; TX overflow
        mo_g[0] = 8'hA1; spi_run("t5a", 8);
        mo_g[0] = 8'hA2; spi_run("t5b", 8);
        mo_g[0] = 8'hA3; pop_bit_g = 7; spi_run("t5c", 8);
        chk("t5 popped 1A1", pop_data_g, 32'h1A1);
        bus_read(0, 2'd1, d);
        chk("t5 count 2", {24'b0, d[15:8]}, 32'd2);
        cpu_read_rx("t5 rx0", d);
        chk("t5 rx 1A2", d, 32'h1A2);
        cpu_read_rx("t5 rx1", d);
        chk("t5 rx 1A3", d, 32'h1A3);
        for (int i = 0; i < DEPTH + 1; i++) cpu_write(2'd0, 32'(8'h60 + i));
        bus_read(0, 2'd1, d);
        chk("t5 tx_overflow", {31'b0, d[5]}, 32'd1);
        check_status("t5");

        // 6: POLARITY=1 instance, three bytes each way
        bus_write(1, 2'd0, 32'h12);
        bus_write(1, 2'd0, 32'h34);
        bus_write(1, 2'd0, 32'h56);
        bus_write(1, 2'd0, 32'h78);
        mo_g[0] = 8'h12; mo_g[1] = 8'h34; mo_g[2] = 8'h56;
        spi_frame(1, 24);
        chk("t6 miso", {8'b0, mi_g[0], mi_g[1], mi_g[2]}, 32'h123456);
        bus_read(1, 2'd0, d); chk("t6 rx0", d, 32'h112);
        bus_read(1, 2'd0, d); chk("t6 rx1", d, 32'h134);
        bus_read(1, 2'd0, d); chk("t6 rx2", d, 32'h156);
        bus_read(1, 2'd1, d);
        chk("t6 errors", {26'b0, d[5:0]}, 32'h04);

        // Randomized traffic against the model
        cpu_write(2'd2, 32'($urandom_range(0, 7)));
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 4))
                0: cpu_write(2'd0, 32'($urandom_range(0, 255)));
                1: cpu_read_rx($sformatf("rnd%0d rx", it), d);
                2: begin
                    for (int i = 0; i < 8; i++) mo_g[i] = 8'($urandom_range(0, 255));
                    spi_run($sformatf("rnd%0d", it), $urandom_range(1, 20));
                end
                3: cpu_write(2'd1, 32'($urandom_range(0, 7)) << 3);
                default: cpu_write(2'd3, 32'($urandom_range(0, 255)));
            endcase
            check_status($sformatf("rnd%0d", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
